// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the FIFO-fed UART transmitter.
//   state_e     - transmitter FSM states
//   DBIT_DEF    - default data bits per frame
//   CPB_DEF     - default clk cycles per serial bit
//   cnt_w()     - counter width for a counter running 0..n-1 (never below 1)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DBIT_DEF = 8;
  localparam int CPB_DEF  = 16;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int TICK_W_DEF = cnt_w(CPB_DEF);
  localparam int BIT_W_DEF  = cnt_w(DBIT_DEF);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: first-word-fall-through FIFO read port.
//   fifo_empty  - FIFO holds no words
//   fifo_r_data - head word, valid whenever fifo_empty=0
//   fifo_rd     - one-cycle pop strobe from the consumer
// master = FIFO side, slave = consumer side.
interface fifo_uart_tx_if #(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd
  );

  modport slave (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: tick counter that paces serial bit periods.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - hold the count at 0 (used while idle)
//   last         - final count of the current period (period length - 1)
//   bit_end      - high on the last cycle of a period; the count wraps to 0
module uart_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic         bit_end
);

  logic [W-1:0] count_q, count_d;

  assign bit_end = (count_q == last);

  always_comb begin
    count_d = count_q + W'(1);
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FWFT FIFO and serialises each byte as a UART frame
// (1 start bit, DBIT data bits LSB first, STOP_BITS stop bits).
//   clk, reset_n  - clock, asynchronous active-low reset
//   tx_en         - permission to start a new frame
//   fifo          - FIFO read port (slave modport: empty, r_data in; rd out)
//   tx            - registered serial line, idles high
//   tx_busy       - frame in progress
//   tx_done_tick  - one-cycle pulse after the last stop bit ends
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT         = DBIT_DEF,
  parameter int CLKS_PER_BIT = CPB_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tx_en,
  fifo_uart_tx_if.slave  fifo,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);

  localparam int TICK_W = cnt_w(STOP_BITS * CLKS_PER_BIT);
  localparam int BIT_W  = cnt_w(DBIT);

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DBIT - 1);

  generate
    if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2) || DBIT < 2) begin : g_bad_param
      $error("fifo_uart_tx: illegal parameters (CLKS_PER_BIT>=2, STOP_BITS in {1,2}, DBIT>=2)");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              pop;
  logic              timer_clr;
  logic [TICK_W-1:0] timer_last;
  logic              bit_end;

  // Mealy pop: the head word is captured on the same edge that advances the
  // FIFO pointer. Gated by reset_n so a held reset can never pop.
  assign pop          = (state_q == IDLE) && tx_en && !fifo.fifo_empty && reset_n;
  assign fifo.fifo_rd = pop;

  // Counter is held at 0 while idle so START always begins a full period.
  assign timer_clr  = (state_q == IDLE);
  assign timer_last = (state_q == STOP) ? STOP_LAST : BIT_LAST;

  uart_bit_timer #(
    .W (TICK_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clr),
    .last    (timer_last),
    .bit_end (bit_end)
  );

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

  // tx_d is the level of the bit period being entered, so tx changes on the
  // edge that starts each period.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shreg_d = fifo.fifo_r_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == DATA_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx.
// dut0: STOP_BITS=1, dut1: STOP_BITS=2 (both DBIT=8, CLKS_PER_BIT=16).
// Each DUT reads a queue-based FIFO model; a monitor rebuilds the expected
// serial waveform of every popped byte from the frame format.
module tb_fifo_uart_tx;

  localparam int CPB = 16;

  logic clk;
  logic rst_n0, rst_n1;
  logic en0, en1;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  fifo_uart_tx_if #(.DBIT(8)) ifc0 ();
  fifo_uart_tx_if #(.DBIT(8)) ifc1 ();

  fifo_uart_tx #(.DBIT(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
    .clk (clk), .reset_n (rst_n0), .tx_en (en0), .fifo (ifc0),
    .tx (tx0), .tx_busy (busy0), .tx_done_tick (done0)
  );

  fifo_uart_tx #(.DBIT(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
    .clk (clk), .reset_n (rst_n1), .tx_en (en1), .fifo (ifc1),
    .tx (tx1), .tx_busy (busy1), .tx_done_tick (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] fq0[$], fq1[$];   // FIFO contents
  logic [7:0] eq0[$], eq1[$];   // scoreboard: bytes expected on the line

  int         cyc = 0;
  int         pops[2], frames[2], idle_err[2], last_pop[2], prev_pop[2];
  bit         in_f[2];
  int         k[2], werr[2];
  logic [7:0] rx[2], cur[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Line level for frame bit index j: start, 8 data LSB first, then stop(s).
  function automatic logic fbit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  task automatic mon(input int d, input logic tx, input logic busy, input logic done,
                     input logic rd, input logic empty, input logic en, input logic rstn);
    int nb;
    int j;
    nb = (d == 0) ? 10 : 11;
    if (!rstn) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd !== 1'b0) idle_err[d]++;
      in_f[d] = 1'b0;
    end else begin
      if (in_f[d]) begin
        k[d]++;
        if (k[d] < nb * CPB) begin
          j = k[d] / CPB;
          if (tx !== fbit(cur[d], j) || busy !== 1'b1 || done !== 1'b0) werr[d]++;
          if ((k[d] % CPB) == CPB / 2 && j >= 1 && j <= 8) rx[d][j-1] = tx;
        end else begin
          chk($sformatf("done_tick_busy_d%0d", d), {30'd0, done, busy}, 32'd2);
          chk($sformatf("byte_d%0d", d), {24'd0, rx[d]}, {24'd0, cur[d]});
          chk($sformatf("wave_errs_d%0d", d), werr[d], 0);
          in_f[d] = 1'b0;
          frames[d]++;
        end
      end else if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        idle_err[d]++;
      end
      if (rd === 1'b1) begin
        chk($sformatf("rd_guard_d%0d", d), {30'd0, empty, en}, 32'd1);
        chk($sformatf("one_pop_per_frame_d%0d", d), {31'd0, in_f[d]}, 0);
        if (d == 0) begin
          chk("pop_has_data_d0", (eq0.size() != 0) ? 32'd1 : 32'd0, 1);
          cur[d] = (eq0.size() != 0) ? eq0.pop_front() : 8'h00;
        end else begin
          chk("pop_has_data_d1", (eq1.size() != 0) ? 32'd1 : 32'd0, 1);
          cur[d] = (eq1.size() != 0) ? eq1.pop_front() : 8'h00;
        end
        in_f[d]     = 1'b1;
        k[d]        = -1;
        werr[d]     = 0;
        rx[d]       = 8'h00;
        pops[d]++;
        prev_pop[d] = last_pop[d];
        last_pop[d] = cyc;
      end else if (rd !== 1'b0) begin
        idle_err[d]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mon(0, tx0, busy0, done0, ifc0.fifo_rd, ifc0.fifo_empty, en0, rst_n0);
      mon(1, tx1, busy1, done1, ifc1.fifo_rd, ifc1.fifo_empty, en1, rst_n1);
    end
  end

  task automatic drive();
    ifc0.fifo_empty  = (fq0.size() == 0);
    ifc0.fifo_r_data = (fq0.size() != 0) ? fq0[0] : 8'h00;
    ifc1.fifo_empty  = (fq1.size() == 0);
    ifc1.fifo_r_data = (fq1.size() != 0) ? fq1[0] : 8'h00;
  endtask

  // One clock: the FIFO model pops on the edge where the DUT strobed rd.
  task automatic step();
    logic r0, r1;
    @(posedge clk);
    r0 = ifc0.fifo_rd;
    r1 = ifc1.fifo_rd;
    #1;
    if (r0 === 1'b1 && fq0.size() != 0) void'(fq0.pop_front());
    if (r1 === 1'b1 && fq1.size() != 0) void'(fq1.pop_front());
    drive();
  endtask

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) begin fq0.push_back(b); eq0.push_back(b); end
    else        begin fq1.push_back(b); eq1.push_back(b); end
    drive();
  endtask

  task automatic wait_frames(input int d, input int target, input int budget);
    int n = 0;
    while (frames[d] < target && n < budget) begin step(); n++; end
    chk($sformatf("frame_done_d%0d_n%0d", d, target), (frames[d] >= target) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic wait_pops(input int d, input int target, input int budget);
    int n = 0;
    while (pops[d] < target && n < budget) begin step(); n++; end
    chk($sformatf("pop_seen_d%0d_n%0d", d, target), (pops[d] >= target) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    int n;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    en0 = 1'b1;    en1 = 1'b1;
    drive();
    repeat (3) step();
    chk("reset_state_d0", {28'd0, tx0, busy0, done0, ifc0.fifo_rd}, 32'h8);
    chk("reset_state_d1", {28'd0, tx1, busy1, done1, ifc1.fifo_rd}, 32'h8);
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // Empty FIFO: nothing may happen.
    repeat (500) step();
    chk("idle_no_pops", pops[0] + pops[1], 0);
    chk("idle_tx_high", {31'd0, tx0}, 1);

    // Single byte.
    push(0, 8'h0F);
    wait_frames(0, 1, 400);
    chk("single_pop_count", pops[0], 1);

    // Back-to-back bytes, then no third pop.
    push(0, 8'h0D);
    push(0, 8'h0C);
    wait_frames(0, 3, 800);
    chk("b2b_gap", last_pop[0] - prev_pop[0], 161);
    repeat (200) step();
    chk("b2b_no_third_pop", pops[0], 3);

    // tx_en dropped mid-frame.
    push(0, 8'hA5);
    push(0, 8'h33);
    wait_pops(0, 4, 50);
    repeat (40) step();
    en0 = 1'b0;
    wait_frames(0, 4, 400);
    repeat (100) step();
    chk("blocked_while_disabled", pops[0], 4);
    en0 = 1'b1;
    #1;
    chk("restart_rd_immediate", {31'd0, ifc0.fifo_rd}, 1);
    wait_frames(0, 5, 400);

    // Reset during data bit 3 of 8'hB3 (that bit is 0 on the line).
    push(0, 8'hB3);
    wait_pops(0, 6, 50);
    repeat (70) step();
    #2;
    rst_n0 = 1'b0;
    #1;
    chk("reset_async_outputs", {28'd0, tx0, busy0, done0, ifc0.fifo_rd}, 32'h8);
    repeat (3) step();
    rst_n0 = 1'b1;
    repeat (100) step();
    chk("post_reset_no_pop", pops[0], 6);
    chk("post_reset_tx_high", {31'd0, tx0}, 1);
    chk("aborted_frame_not_done", frames[0], 5);

    // Two stop bits.
    push(1, 8'h83);
    wait_frames(1, 1, 400);

    // Random traffic with random tx_en gaps on dut0.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) push(0, 8'($urandom));
      if ($urandom_range(0, 149) == 0) push(1, 8'($urandom));
      if ($urandom_range(0, 399) == 0) en0 = ~en0;
      step();
    end
    en0 = 1'b1;
    n = 0;
    while ((eq0.size() != 0 || eq1.size() != 0 || in_f[0] || in_f[1]) && n < 20000) begin
      step();
      n++;
    end
    chk("random_drained", eq0.size() + eq1.size() + int'(in_f[0]) + int'(in_f[1]), 0);
    repeat (5) step();

    chk("idle_line_d0", idle_err[0], 0);
    chk("idle_line_d1", idle_err[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's synchronous FIFO. It drains bytes using the FIFO's first-word-fall-through read port (empty, r_data, rd) and serialises each byte as an asynchronous UART frame: 1 start bit, DBIT data bits LSB first, then STOP_BITS stop bits. It sits between a FIFO instance and the chip's serial TX pin.

Parameters:
DBIT, 8, data bits per frame; must match the FIFO word width b.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  reset, asynchronous, active-low.
tx_en  in  1  start-permission; when low, no new frame starts.
fifo_empty  in  1  FIFO empty flag.
fifo_r_data  in  DBIT  FIFO head word, valid whenever fifo_empty=0.
fifo_rd  out  1  one-cycle pop strobe to the FIFO.
tx  out  DBIT-independent, 1  serial line; idles high; registered.
tx_busy  out  1  high while a frame is in progress (any state other than IDLE).
tx_done_tick  out  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, fifo_rd=0.
  - all counters and the shift register are cleared.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - fifo_rd = tx_en & ~fifo_empty. This is combinational (Mealy) and gated to 0 while reset_n=0.
  - On the edge where fifo_rd=1: capture fifo_r_data into the shift register, clear the tick counter, go to START.
  - Capture and pop happen on the same edge. This matches FIFO semantics, where r_data is the head word and rd advances the pointer.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0, held for CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right; bit counter +1.
  - After bit DBIT-1, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then tx_done_tick=1 for exactly one cycle and go to IDLE.
- Timing:
  - tx changes on the clk edge that enters each bit period.
  - Minimum frame-to-frame spacing is (1+DBIT+STOP_BITS)*CLKS_PER_BIT + 1 cycles, because one IDLE cycle is always spent.
- Counter widths:
  - Tick counter is clog2(STOP_BITS*CLKS_PER_BIT) bits; it counts 0..limit-1 and reloads to 0.
  - Bit counter is clog2(DBIT) bits.
  - No overflow is possible.
- Boundary conditions:
  - fifo_empty=1 in IDLE: no pop, tx stays 1, tx_busy=0.
  - fifo_empty or fifo_r_data changing mid-frame: ignored, because the byte is already latched.
  - tx_en falling mid-frame: the current frame completes normally; the next frame is blocked until tx_en=1.
  - Exactly one fifo_rd pulse per frame. fifo_rd is never asserted when fifo_empty=1, so the block never pops an empty FIFO.
  - Reset mid-frame: tx returns to 1 immediately and the in-flight byte is discarded (not re-read). After release the block starts in IDLE.
  - Illegal parameters (CLKS_PER_BIT<2, STOP_BITS not 1 or 2): elaboration-time error.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - default DBIT and CLKS_PER_BIT constants;
  - clog2-based width constants.
- One sub-module, uart_bit_timer:
  - tick counter with load/clear;
  - output bit_end pulse, asserted when the count reaches the programmable limit;
  - the FSM drives it with limit = CLKS_PER_BIT, or STOP_BITS*CLKS_PER_BIT in STOP.

Test Plan:
(All scenarios use the defaults DBIT=8, CLKS_PER_BIT=16, STOP_BITS=1 unless stated.)
1. Idle/reset: reset_n low 3 cycles, then high, with fifo_empty=1 for 500 cycles -> tx=1, fifo_rd=0, tx_busy=0 throughout.
2. Single byte 8'h0F:
   - stimulus: fifo_empty=0, tx_en=1;
   - fifo_rd pulses once;
   - tx waveform: 0 for 16 cycles, then data bits 1,1,1,1,0,0,0,0 at 16 cycles each, then stop bit 1 for 16 cycles;
   - tx_done_tick rises 160 cycles after frame start.
3. Back-to-back bytes 8'h0D then 8'h0C preloaded in the FIFO -> exactly 2 fifo_rd pulses, 161 cycles apart; the decoded bytes match in order; fifo_empty is high afterwards with no third pop.
4. tx_en dropped 40 cycles into frame 8'hA5 with 8'h33 still queued -> 8'hA5 completes; no fifo_rd while tx_en=0; 8'h33 starts 1 cycle after tx_en returns high.
5. reset_n asserted during data bit 3 of 8'hB3 -> tx=1 and tx_busy=0 in the same timestep; after release with fifo_empty=1, no pop and tx stays 1.
6. STOP_BITS=2, byte 8'h83 -> stop-high period is 32 cycles; tx_done_tick arrives 176 cycles after frame start.
